// File: rtl/dm_arbiter_if.sv
// Requester and data-memory signal bundle for dm_arbiter.
// The arbiter connects through the slave modport; requesters and the memory model use master.
interface dm_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_byte;
  logic [31:0]       m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_byte;
  logic [31:0]       m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [31:0]       m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_byte, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_rdata,
    input  m1_req, m1_we, m1_byte, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_byte, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata,
    output m1_req, m1_we, m1_byte, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported synchronous-read word memory.
// Handles word load/store, sign-extended byte load, and byte store as read-modify-write.
//
// state | meaning
// IDLE  | waiting for a request; accept and latch operands
// RD    | memory read of the latched word
// CAP   | capture read word; form load result or merged store word
// WR    | memory write of latched or merged word
// RESP  | done pulse to the owner
module dm_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic          clk,
  input  logic          reset,
  dm_arbiter_if.slave   bus,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

  state_t            state;
  state_t            stateNext;
  logic              ptr;
  logic              owner;
  logic              weLat;
  logic              byteLat;
  logic [ADDR_W-1:0] addrLat;
  logic [31:0]       wdataLat;
  logic [31:0]       capWord;
  logic [31:0]       m0Rdata;
  logic [31:0]       m1Rdata;

  logic              accept;
  logic              winner;
  logic [7:0]        rdLane;
  logic [31:0]       loadVal;
  logic [31:0]       mergedWord;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{bus.m0_addr[31:ADDR_W], bus.m1_addr[31:ADDR_W]};

  assign accept = (state == IDLE) && (bus.m0_req || bus.m1_req);
  // winner: 1 selects m1; the pointer only matters when both ask
  assign winner = bus.m1_req && (!bus.m0_req || ptr);

  always_comb begin
    rdLane = bus.mem_rdata[7:0];
    case (addrLat[1:0])
      2'd0: rdLane = bus.mem_rdata[7:0];
      2'd1: rdLane = bus.mem_rdata[15:8];
      2'd2: rdLane = bus.mem_rdata[23:16];
      2'd3: rdLane = bus.mem_rdata[31:24];
      default: rdLane = bus.mem_rdata[7:0];
    endcase
    loadVal = byteLat ? {{24{rdLane[7]}}, rdLane} : bus.mem_rdata;
  end

  always_comb begin
    mergedWord = capWord;
    case (addrLat[1:0])
      2'd0: mergedWord[7:0]   = wdataLat[7:0];
      2'd1: mergedWord[15:8]  = wdataLat[7:0];
      2'd2: mergedWord[23:16] = wdataLat[7:0];
      2'd3: mergedWord[31:24] = wdataLat[7:0];
      default: mergedWord = capWord;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (winner ? (bus.m1_we && !bus.m1_byte) : (bus.m0_we && !bus.m0_byte))
            stateNext = WR;
          else
            stateNext = RD;
        end
      end
      RD:      stateNext = CAP;
      CAP:     stateNext = weLat ? WR : RESP;
      WR:      stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en  = (state == RD) || (state == WR);
    bus.mem_we  = (state == WR);
    bus.m0_gnt  = accept && !winner;
    bus.m1_gnt  = accept && winner;
    bus.m0_done = (state == RESP) && !owner;
    bus.m1_done = (state == RESP) && owner;
    busy        = (state != IDLE);
  end

  assign bus.mem_addr  = addrLat[ADDR_W-1:2];
  assign bus.mem_wdata = byteLat ? mergedWord : wdataLat;
  assign bus.m0_rdata  = m0Rdata;
  assign bus.m1_rdata  = m1Rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      weLat    <= 1'b0;
      byteLat  <= 1'b0;
      addrLat  <= '0;
      wdataLat <= '0;
      capWord  <= '0;
      m0Rdata  <= '0;
      m1Rdata  <= '0;
    end else begin
      if (accept) begin
        ptr      <= ~winner;
        owner    <= winner;
        weLat    <= winner ? bus.m1_we   : bus.m0_we;
        byteLat  <= winner ? bus.m1_byte : bus.m0_byte;
        addrLat  <= winner ? bus.m1_addr[ADDR_W-1:0] : bus.m0_addr[ADDR_W-1:0];
        wdataLat <= winner ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == CAP) begin
        capWord <= bus.mem_rdata;
        // result registered here so it is already valid alongside done
        if (!weLat) begin
          if (owner) m1Rdata <= loadVal;
          else       m0Rdata <= loadVal;
        end
      end
    end
  end

endmodule
